// File: rtl/juggle_pkg.sv
// rtl/juggle_pkg.sv - shared constants, FSM states and ball start-phase table for the juggling trajectory generator

package juggle_pkg;
   localparam int FLIGHT  = 32;
   localparam int P       = 40;
   localparam int PHASE_W = 6;
   localparam int NBALLS  = 7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_UPDATE,
      S_COMMIT
   } state_t;

   // floor(i*P/n) for ball i of n; entries for i >= n are never used
   localparam logic [PHASE_W-1:0] PHASE_INIT [8][NBALLS] = '{
      '{6'd0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0},
      '{6'd0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0},
      '{6'd0, 6'd20, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0},
      '{6'd0, 6'd13, 6'd26, 6'd0,  6'd0,  6'd0,  6'd0},
      '{6'd0, 6'd10, 6'd20, 6'd30, 6'd0,  6'd0,  6'd0},
      '{6'd0, 6'd8,  6'd16, 6'd24, 6'd32, 6'd0,  6'd0},
      '{6'd0, 6'd6,  6'd13, 6'd20, 6'd26, 6'd33, 6'd0},
      '{6'd0, 6'd5,  6'd11, 6'd17, 6'd22, 6'd28, 6'd34}
   };
endpackage

// File: rtl/traj_point_calc.sv
// rtl/traj_point_calc.sv - combinational position of one ball from its phase and the two hand positions

module traj_point_calc
   import juggle_pkg::*;
#(
   parameter int FLIGHT_LOG2 = 5,
   parameter int HOLD_FRAMES = 8,
   parameter int APEX        = 200
) (
   input  logic [PHASE_W-1:0] phase,
   input  logic               h,
   input  logic [10:0]        hand_x [1:0],
   input  logic [9:0]         hand_y [1:0],
   output logic [10:0]        x,
   output logic [9:0]         y
);
   localparam int FLT = 1 << FLIGHT_LOG2;

   logic [PHASE_W-1:0] t;
   logic [10:0]        hx_h;
   logic [10:0]        hx_o;
   logic [9:0]         hy_h;
   logic signed [11:0] dx;
   logic signed [18:0] prod;
   logic [23:0]        arc;

   always_comb begin
      hx_h = hand_x[h];
      hx_o = hand_x[~h];
      hy_h = hand_y[h];
      t    = phase - PHASE_W'(HOLD_FRAMES);
      dx   = $signed({1'b0, hx_o}) - $signed({1'b0, hx_h});
      prod = 19'(dx) * 19'($signed({1'b0, t}));
      // parabola 4*APEX*t*(F-t)/F^2 peaks at APEX when t = F/2
      arc  = (24'(4 * APEX) * 24'(t) * (24'(FLT) - 24'(t))) >> (2 * FLIGHT_LOG2);
      if (phase < PHASE_W'(HOLD_FRAMES)) begin
         x = hx_h;
         y = hy_h;
      end else begin
         x = 11'($signed({1'b0, hx_h}) + (prod >>> FLIGHT_LOG2));
         y = (arc > 24'(hy_h)) ? 10'd0 : 10'(24'(hy_h) - arc);
      end
   end
endmodule

// File: rtl/trajectory_generator.sv
// rtl/trajectory_generator.sv - per-frame juggling ball trajectory generator, one ball evaluated per cycle

module trajectory_generator
   import juggle_pkg::*;
#(
   parameter int FLIGHT_LOG2 = 5,
   parameter int HOLD_FRAMES = 8,
   parameter int APEX        = 200
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        new_frame,
   input  logic [2:0]  num_balls,
   input  logic [10:0] hand_x_in [1:0],
   input  logic [9:0]  hand_y_in [1:0],
   output logic [10:0] traj_x_out [6:0],
   output logic [9:0]  traj_y_out [6:0],
   output logic        traj_valid
);
   state_t             state, state_n;
   logic [2:0]         idx;
   logic [2:0]         sel;
   logic [2:0]         nb_reg;
   logic               load_req;
   logic               reinit;
   logic               issue;
   logic               active;
   logic [PHASE_W-1:0] ball_phase [NBALLS];
   logic               ball_hand  [NBALLS];
   logic [10:0]        shadow_x   [NBALLS];
   logic [9:0]         shadow_y   [NBALLS];
   logic [10:0]        calc_x;
   logic [9:0]         calc_y;
   logic [10:0]        pipe_x;
   logic [9:0]         pipe_y;
   logic [2:0]         pipe_idx;
   logic               pipe_vld;

   assign reinit = load_req || (num_balls != nb_reg);
   // idx 7 is the drain slot that lets ball 6 land in the shadow buffer
   assign issue  = (state == S_UPDATE) && (idx != 3'd7);
   assign active = idx < nb_reg;
   assign sel    = (idx == 3'd7) ? 3'd0 : idx;

   traj_point_calc #(
      .FLIGHT_LOG2 (FLIGHT_LOG2),
      .HOLD_FRAMES (HOLD_FRAMES),
      .APEX        (APEX)
   ) u_calc (
      .phase  (ball_phase[sel]),
      .h      (ball_hand[sel]),
      .hand_x (hand_x_in),
      .hand_y (hand_y_in),
      .x      (calc_x),
      .y      (calc_y)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (reinit) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (new_frame) state_n = S_UPDATE;
            S_UPDATE: if (idx == 3'd7) state_n = S_COMMIT;
            S_COMMIT: state_n = S_IDLE;
            default:  state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         idx        <= '0;
         nb_reg     <= '0;
         load_req   <= 1'b1;
         traj_valid <= 1'b0;
         pipe_vld   <= 1'b0;
         pipe_idx   <= '0;
         pipe_x     <= '0;
         pipe_y     <= '0;
         for (int i = 0; i < NBALLS; i++) begin
            ball_phase[i] <= '0;
            ball_hand[i]  <= 1'b0;
            shadow_x[i]   <= '0;
            shadow_y[i]   <= '0;
            traj_x_out[i] <= '0;
            traj_y_out[i] <= '0;
         end
      end else begin
         load_req <= 1'b0;
         if (reinit) begin
            nb_reg     <= num_balls;
            traj_valid <= 1'b0;
            pipe_vld   <= 1'b0;
            idx        <= '0;
            for (int i = 0; i < NBALLS; i++) begin
               ball_phase[i] <= PHASE_INIT[num_balls][i];
               ball_hand[i]  <= 1'(i);
            end
         end else begin
            pipe_vld <= issue;
            pipe_idx <= idx;
            pipe_x   <= active ? calc_x : 11'd0;
            pipe_y   <= active ? calc_y : 10'd0;
            if (issue && active) begin
               if (ball_phase[sel] == PHASE_W'(P - 1)) begin
                  ball_phase[sel] <= '0;
                  ball_hand[sel]  <= ~ball_hand[sel];
               end else begin
                  ball_phase[sel] <= ball_phase[sel] + 1'b1;
               end
            end
            if (pipe_vld) begin
               shadow_x[pipe_idx] <= pipe_x;
               shadow_y[pipe_idx] <= pipe_y;
            end
            idx <= (state == S_UPDATE) ? idx + 3'd1 : 3'd0;
            if (state == S_COMMIT) begin
               for (int i = 0; i < NBALLS; i++) begin
                  traj_x_out[i] <= shadow_x[i];
                  traj_y_out[i] <= shadow_y[i];
               end
               if (nb_reg != 3'd0) traj_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_trajectory_generator.sv
// tb/tb_trajectory_generator.sv - directed self-checking bench for trajectory_generator

module tb_trajectory_generator;
   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        new_frame = 1'b0;
   logic [2:0]  num_balls = 3'd1;
   logic [10:0] hand_x [1:0];
   logic [9:0]  hand_y [1:0];
   logic [10:0] traj_x [6:0];
   logic [9:0]  traj_y [6:0];
   logic        traj_valid;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   trajectory_generator dut (
      .clk_in     (clk),
      .rst_in     (rst),
      .new_frame  (new_frame),
      .num_balls  (num_balls),
      .hand_x_in  (hand_x),
      .hand_y_in  (hand_y),
      .traj_x_out (traj_x),
      .traj_y_out (traj_y),
      .traj_valid (traj_valid)
   );

   task automatic pulse_frame;
      @(negedge clk) new_frame = 1'b1;
      @(negedge clk) new_frame = 1'b0;
   endtask

   task automatic run_frame;
      pulse_frame();
      repeat (9) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int b = 0; b < 7; b++) begin
         checks++;
         if (traj_x[b] !== 11'd0 || traj_y[b] !== 10'd0) begin
            errors++;
            $display("FAIL reset_pos ball %0d got (%0d,%0d) want (0,0)", b, traj_x[b], traj_y[b]);
         end
      end
      checks++;
      if (traj_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got %b want 0", traj_valid);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      pulse_frame();
      repeat (8) @(negedge clk);
      checks++;
      if (traj_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early valid got %b want 0 at cycle 8", traj_valid);
      end
      @(negedge clk);
      checks++;
      if (traj_valid !== 1'b1) begin
         errors++;
         $display("FAIL latency_valid got %b want 1 at cycle 9", traj_valid);
      end
      checks++;
      if (traj_x[0] !== 11'd100 || traj_y[0] !== 10'd400) begin
         errors++;
         $display("FAIL frame0_pos got (%0d,%0d) want (100,400)", traj_x[0], traj_y[0]);
      end
   endtask

   task automatic test_hold;
      for (int f = 1; f <= 8; f++) begin
         run_frame();
         checks++;
         if (traj_x[0] !== 11'd100 || traj_y[0] !== 10'd400) begin
            errors++;
            $display("FAIL hold frame %0d got (%0d,%0d) want (100,400)", f, traj_x[0], traj_y[0]);
         end
      end
   endtask

   task automatic test_apex;
      logic [10:0] ex;
      logic [9:0]  ey;
      for (int f = 9; f <= 39; f++) begin
         run_frame();
         if (f == 16 || f == 24 || f == 39) begin
            ex = (f == 16) ? 11'd200 : (f == 24) ? 11'd300 : 11'd487;
            ey = (f == 16) ? 10'd250 : (f == 24) ? 10'd200 : 10'd376;
            checks++;
            if (traj_x[0] !== ex || traj_y[0] !== ey) begin
               errors++;
               $display("FAIL flight frame %0d got (%0d,%0d) want (%0d,%0d)", f, traj_x[0], traj_y[0], ex, ey);
            end
         end
      end
   endtask

   task automatic test_wrap;
      logic [10:0] ex;
      logic [9:0]  ey;
      for (int f = 40; f <= 56; f++) begin
         run_frame();
         if (f == 40 || f == 48 || f == 56) begin
            ex = (f == 56) ? 11'd400 : 11'd500;
            ey = (f == 56) ? 10'd250 : 10'd400;
            checks++;
            if (traj_x[0] !== ex || traj_y[0] !== ey) begin
               errors++;
               $display("FAIL wrap frame %0d got (%0d,%0d) want (%0d,%0d)", f, traj_x[0], traj_y[0], ex, ey);
            end
         end
         if (f == 40) begin
            for (int b = 1; b < 7; b++) begin
               checks++;
               if (traj_x[b] !== 11'd0 || traj_y[b] !== 10'd0) begin
                  errors++;
                  $display("FAIL unused ball %0d got (%0d,%0d) want (0,0)", b, traj_x[b], traj_y[b]);
               end
            end
         end
      end
   endtask

   task automatic test_num_change;
      logic [10:0] ex3 [7] = '{11'd100, 11'd437, 11'd325, 11'd0, 11'd0, 11'd0, 11'd0};
      logic [9:0]  ey3 [7] = '{10'd400, 10'd295, 10'd204, 10'd0, 10'd0, 10'd0, 10'd0};
      logic [10:0] ex5 [7] = '{11'd100, 11'd500, 11'd200, 11'd300, 11'd400, 11'd0, 11'd0};
      logic [9:0]  ey5 [7] = '{10'd400, 10'd400, 10'd250, 10'd200, 10'd250, 10'd0, 10'd0};
      @(negedge clk) num_balls = 3'd3;
      @(negedge clk);
      checks++;
      if (traj_valid !== 1'b0) begin
         errors++;
         $display("FAIL n3_reload_valid got %b want 0", traj_valid);
      end
      run_frame();
      checks++;
      if (traj_valid !== 1'b1) begin
         errors++;
         $display("FAIL n3_valid got %b want 1", traj_valid);
      end
      for (int b = 0; b < 7; b++) begin
         checks++;
         if (traj_x[b] !== ex3[b] || traj_y[b] !== ey3[b]) begin
            errors++;
            $display("FAIL n3 ball %0d got (%0d,%0d) want (%0d,%0d)", b, traj_x[b], traj_y[b], ex3[b], ey3[b]);
         end
      end
      pulse_frame();
      repeat (2) @(negedge clk);
      num_balls = 3'd5;
      @(negedge clk);
      checks++;
      if (traj_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_valid got %b want 0", traj_valid);
      end
      repeat (12) @(negedge clk);
      checks++;
      if (traj_x[1] !== 11'd437 || traj_y[1] !== 10'd295 || traj_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_hold got (%0d,%0d) valid %b want (437,295) valid 0", traj_x[1], traj_y[1], traj_valid);
      end
      run_frame();
      checks++;
      if (traj_valid !== 1'b1) begin
         errors++;
         $display("FAIL n5_valid got %b want 1", traj_valid);
      end
      for (int b = 0; b < 7; b++) begin
         checks++;
         if (traj_x[b] !== ex5[b] || traj_y[b] !== ey5[b]) begin
            errors++;
            $display("FAIL n5 ball %0d got (%0d,%0d) want (%0d,%0d)", b, traj_x[b], traj_y[b], ex5[b], ey5[b]);
         end
      end
   endtask

   task automatic test_ignore_pulses;
      logic [10:0] prev;
      int          commits;
      prev    = traj_x[2];
      commits = 0;
      pulse_frame();
      for (int c = 1; c <= 20; c++) begin
         if (c == 3 || c == 9)  new_frame = 1'b1;
         if (c == 4 || c == 10) new_frame = 1'b0;
         @(negedge clk);
         if (traj_x[2] !== prev) commits++;
         prev = traj_x[2];
         if (c == 9) begin
            checks++;
            if (traj_x[2] !== 11'd212 || traj_y[2] !== 10'd239) begin
               errors++;
               $display("FAIL ignore_commit got (%0d,%0d) want (212,239)", traj_x[2], traj_y[2]);
            end
         end
      end
      checks++;
      if (commits !== 1) begin
         errors++;
         $display("FAIL ignore_count commits got %0d want 1", commits);
      end
      checks++;
      if (traj_x[2] !== 11'd212 || traj_y[2] !== 10'd239) begin
         errors++;
         $display("FAIL ignore_final got (%0d,%0d) want (212,239)", traj_x[2], traj_y[2]);
      end
   endtask

   task automatic test_zero_balls;
      @(negedge clk) num_balls = 3'd0;
      @(negedge clk);
      run_frame();
      checks++;
      if (traj_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_valid got %b want 0", traj_valid);
      end
      for (int b = 0; b < 7; b++) begin
         checks++;
         if (traj_x[b] !== 11'd0 || traj_y[b] !== 10'd0) begin
            errors++;
            $display("FAIL zero ball %0d got (%0d,%0d) want (0,0)", b, traj_x[b], traj_y[b]);
         end
      end
   endtask

   initial begin
      hand_x[0] = 11'd100;
      hand_x[1] = 11'd500;
      hand_y[0] = 10'd400;
      hand_y[1] = 10'd400;
      test_reset();
      test_hold();
      test_apex();
      test_wrap();
      test_num_change();
      test_ignore_pulses();
      test_zero_balls();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
